// File: rtl/instruction_cycle_controller.sv
// Instruction cycle controller: sequences FETCH / DECODE / EXECUTE / MEM /
// WRITEBACK for a small load/store machine, with a memory-wait timeout that
// parks the controller in FAULT until reset.
module instruction_cycle_controller (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic [2:0]  id,
    input  logic        memReady,
    output logic        pcRead,
    output logic        irLoad,
    output logic        aluControl,
    output logic        registerWrite,
    output logic        memoryRead,
    output logic        writeMemory,
    output logic        isStore,
    output logic        pcIncrement,
    output logic        pcLoad,
    output logic        clockCounterEnabled,
    output logic        busy,
    output logic        instrDone,
    output logic        fault,
    output logic [15:0] cycleCount
);

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_JUMP  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    typedef struct packed {
        logic pc_read;
        logic ir_load;
        logic alu_control;
        logic register_write;
        logic memory_read;
        logic write_memory;
        logic is_store;
        logic pc_increment;
        logic pc_load;
        logic busy;
        logic instr_done;
        logic fault;
    } strobes_t;

    // Moore decode of the datapath strobes for a given state and latched opcode
    function automatic strobes_t decode_strobes(input state_t st, input logic [2:0] op_v);
        strobes_t s;
        s = strobes_t'(12'd0);
        case (st)
            ST_IDLE: begin
                s = strobes_t'(12'd0);
            end
            ST_FETCH: begin
                s.pc_read = 1'b1;
                s.ir_load = 1'b1;
                s.busy    = 1'b1;
            end
            ST_DECODE: begin
                s.busy = 1'b1;
            end
            ST_EXECUTE: begin
                s.busy = 1'b1;
                case (op_v)
                    OP_ALU: begin
                        s.alu_control    = 1'b1;
                        s.register_write = 1'b1;
                        s.pc_increment   = 1'b1;
                        s.instr_done     = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        s.alu_control = 1'b1;
                    end
                    OP_JUMP: begin
                        s.pc_load    = 1'b1;
                        s.instr_done = 1'b1;
                    end
                    default: begin
                        s.pc_increment = 1'b1;
                        s.instr_done   = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                s.busy = 1'b1;
                if (op_v == OP_LOAD) begin
                    s.memory_read = 1'b1;
                end else if (op_v == OP_STORE) begin
                    s.write_memory = 1'b1;
                    s.is_store     = 1'b1;
                end else begin
                    s.memory_read  = 1'b0;
                    s.write_memory = 1'b0;
                end
            end
            ST_WRITEBACK: begin
                s.busy           = 1'b1;
                s.register_write = 1'b1;
                s.pc_increment   = 1'b1;
                s.instr_done     = 1'b1;
            end
            ST_FAULT: begin
                s.fault = 1'b1;
            end
            default: begin
                s = strobes_t'(12'd0);
            end
        endcase
        return s;
    endfunction

    state_t      r_state;
    logic [2:0]  r_op;
    logic [3:0]  r_wait;
    logic [15:0] r_cycle_count;
    strobes_t    r_strobes;

    state_t      w_next_state;
    logic [2:0]  w_next_op;
    logic [3:0]  w_next_wait;
    logic [15:0] w_next_count;
    logic        w_instr_end;
    logic        w_counting;
    logic        w_store_done;

    // cycle counter runs in every active (busy) state
    assign w_counting = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                        (r_state == ST_EXECUTE) || (r_state == ST_MEM) ||
                        (r_state == ST_WRITEBACK);

    // a store retires in its MEM cycle as soon as memory acknowledges
    assign w_store_done = (r_state == ST_MEM) && (r_op == OP_STORE) && memReady;

    // next-state, opcode latch, wait counter and cycle counter computation
    always_comb begin
        w_next_state = r_state;
        w_next_op    = r_op;
        w_next_wait  = r_wait;
        w_instr_end  = 1'b0;
        if (w_counting && (r_cycle_count != 16'hFFFF)) begin
            w_next_count = r_cycle_count + 16'd1;
        end else begin
            w_next_count = r_cycle_count;
        end
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_FETCH;
                    w_next_count = 16'd0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FETCH: begin
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                w_next_state = ST_EXECUTE;
                w_next_op    = id;
            end
            ST_EXECUTE: begin
                if ((r_op == OP_LOAD) || (r_op == OP_STORE)) begin
                    w_next_state = ST_MEM;
                    w_next_wait  = 4'd0;
                end else begin
                    w_instr_end = 1'b1;
                end
            end
            ST_MEM: begin
                if (memReady) begin
                    if (r_op == OP_LOAD) begin
                        w_next_state = ST_WRITEBACK;
                    end else begin
                        w_instr_end = 1'b1;
                    end
                end else if (r_wait == 4'd15) begin
                    w_next_state = ST_FAULT;
                end else begin
                    w_next_wait = r_wait + 4'd1;
                end
            end
            ST_WRITEBACK: begin
                w_instr_end = 1'b1;
            end
            ST_FAULT: begin
                w_next_state = ST_FAULT;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        // run enable is only consulted at instruction boundaries, so a
        // falling start never aborts an instruction in flight
        if (w_instr_end) begin
            w_next_state = start ? ST_FETCH : ST_IDLE;
        end else begin
            w_next_state = w_next_state;
        end
    end

    // state, opcode, counters and registered strobes; reset clears all at once
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= ST_IDLE;
            r_op          <= 3'b000;
            r_wait        <= 4'd0;
            r_cycle_count <= 16'd0;
            r_strobes     <= strobes_t'(12'd0);
        end else begin
            r_state       <= w_next_state;
            r_op          <= w_next_op;
            r_wait        <= w_next_wait;
            r_cycle_count <= w_next_count;
            r_strobes     <= decode_strobes(w_next_state, w_next_op);
        end
    end

    assign pcRead              = r_strobes.pc_read;
    assign irLoad              = r_strobes.ir_load;
    assign aluControl          = r_strobes.alu_control;
    assign registerWrite       = r_strobes.register_write;
    assign memoryRead          = r_strobes.memory_read;
    assign writeMemory         = r_strobes.write_memory;
    assign isStore             = r_strobes.is_store;
    assign pcIncrement         = r_strobes.pc_increment | w_store_done;
    assign pcLoad              = r_strobes.pc_load;
    assign clockCounterEnabled = r_strobes.busy;
    assign busy                = r_strobes.busy;
    assign instrDone           = r_strobes.instr_done | w_store_done;
    assign fault               = r_strobes.fault;
    assign cycleCount          = r_cycle_count;

endmodule

// File: tb/tb_instruction_cycle_controller.sv
// Self-checking bench for instruction_cycle_controller: a table of
// per-instruction expectations run through a scoreboard queue, plus
// hand-written reset, back-to-back, timeout/fault and async-reset sequences.
module tb_instruction_cycle_controller;

    logic        clk;
    logic        resetN;
    logic        start;
    logic [2:0]  id;
    logic        memReady;
    logic        pcRead, irLoad, aluControl, registerWrite, memoryRead;
    logic        writeMemory, isStore, pcIncrement, pcLoad;
    logic        clockCounterEnabled, busy, instrDone, fault;
    logic [15:0] cycleCount;

    int n_checks = 0;
    int n_fail   = 0;
    int n_edges  = 0;

    instruction_cycle_controller dut (
        .clk(clk), .resetN(resetN), .start(start), .id(id), .memReady(memReady),
        .pcRead(pcRead), .irLoad(irLoad), .aluControl(aluControl),
        .registerWrite(registerWrite), .memoryRead(memoryRead),
        .writeMemory(writeMemory), .isStore(isStore), .pcIncrement(pcIncrement),
        .pcLoad(pcLoad), .clockCounterEnabled(clockCounterEnabled), .busy(busy),
        .instrDone(instrDone), .fault(fault), .cycleCount(cycleCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) n_edges++;

    typedef struct {
        logic [2:0] id;
        int waits;
        int lat;
        int alu;
        int rw;
        int mr;
        int wm;
        int st;
        int pci;
        int pcl;
        int done;
    } vec_t;

    vec_t vecs[12];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [12:0] get_outs();
        return {pcRead, irLoad, aluControl, registerWrite, memoryRead, writeMemory,
                isStore, pcIncrement, pcLoad, clockCounterEnabled, busy, instrDone, fault};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        int mem_idx = 0, lat = 0, n_alu = 0, n_rw = 0, n_mr = 0, n_wm = 0, n_st = 0;
        int n_pci = 0, n_pcl = 0, n_done = 0, n_pcr = 0, n_irl = 0, n_both = 0, n_flt = 0;
        logic fin = 1'b0;
        string tag;
        exp_q.push_back(v);
        start = 1'b1;
        id = v.id;
        memReady = 1'b0;
        for (int c = 1; c <= 40 && !fin; c++) begin
            step();
            if (c == 1) start = 1'b0;
            if (c >= 3) id = ~v.id;
            if (memoryRead || writeMemory) begin
                memReady = (mem_idx >= v.waits);
                mem_idx++;
            end else begin
                memReady = 1'($urandom_range(0, 1));
            end
            #1;
            if (!busy) begin
                fin = 1'b1;
            end else begin
                lat++;
                n_alu  += int'(aluControl);
                n_rw   += int'(registerWrite);
                n_mr   += int'(memoryRead);
                n_wm   += int'(writeMemory);
                n_st   += int'(isStore);
                n_pci  += int'(pcIncrement);
                n_pcl  += int'(pcLoad);
                n_done += int'(instrDone);
                n_pcr  += int'(pcRead);
                n_irl  += int'(irLoad);
                n_both += int'(memoryRead && writeMemory);
            end
            n_flt += int'(fault);
        end
        memReady = 1'b0;
        e = exp_q.pop_front();
        tag = $sformatf("vec%0d_id%03b", idx, e.id);
        check({tag, "_finished"}, 32'(fin), 32'd1);
        check({tag, "_latency"}, lat, e.lat);
        check({tag, "_cycleCount"}, 32'(cycleCount), e.lat);
        check({tag, "_aluControl"}, n_alu, e.alu);
        check({tag, "_registerWrite"}, n_rw, e.rw);
        check({tag, "_memoryRead"}, n_mr, e.mr);
        check({tag, "_writeMemory"}, n_wm, e.wm);
        check({tag, "_isStore"}, n_st, e.st);
        check({tag, "_pcIncrement"}, n_pci, e.pci);
        check({tag, "_pcLoad"}, n_pcl, e.pcl);
        check({tag, "_instrDone"}, n_done, e.done);
        check({tag, "_pcRead"}, n_pcr, 1);
        check({tag, "_irLoad"}, n_irl, 1);
        check({tag, "_rd_wr_overlap"}, n_both, 0);
        check({tag, "_fault"}, n_flt, 0);
    endtask

    initial begin
        int n_done;
        int pcl_cycle;
        int n_wm;
        int edges0;
        logic got;

        //            id      wt lat alu rw mr  wm  st  pci pcl done
        vecs[0]  = '{3'b000,  0,  3, 1, 1,  0,  0,  0, 1, 0, 1};
        vecs[1]  = '{3'b010,  2,  7, 1, 1,  3,  0,  0, 1, 0, 1};
        vecs[2]  = '{3'b010,  0,  5, 1, 1,  1,  0,  0, 1, 0, 1};
        vecs[3]  = '{3'b010, 15, 20, 1, 1, 16,  0,  0, 1, 0, 1};
        vecs[4]  = '{3'b100,  0,  4, 1, 0,  0,  1,  1, 1, 0, 1};
        vecs[5]  = '{3'b100,  3,  7, 1, 0,  0,  4,  4, 1, 0, 1};
        vecs[6]  = '{3'b100, 15, 19, 1, 0,  0, 16, 16, 1, 0, 1};
        vecs[7]  = '{3'b011,  0,  3, 0, 0,  0,  0,  0, 0, 1, 1};
        vecs[8]  = '{3'b111,  0,  3, 0, 0,  0,  0,  0, 1, 0, 1};
        vecs[9]  = '{3'b001,  0,  3, 0, 0,  0,  0,  0, 1, 0, 1};
        vecs[10] = '{3'b101,  0,  3, 0, 0,  0,  0,  0, 1, 0, 1};
        vecs[11] = '{3'b110,  0,  3, 0, 0,  0,  0,  0, 1, 0, 1};

        // reset state
        resetN = 1'b0;
        start = 1'b0;
        id = 3'b000;
        memReady = 1'b0;
        #2;
        check("reset_outputs", 32'(get_outs()), 32'd0);
        check("reset_cycleCount", 32'(cycleCount), 32'd0);
        step();
        resetN = 1'b1;
        for (int c = 0; c < 3; c++) step();
        check("idle_without_start", 32'(busy), 32'd0);

        // table-driven instructions
        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // back-to-back ALU then JUMP with start held
        start = 1'b1;
        id = 3'b000;
        n_done = 0;
        pcl_cycle = 0;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 3) id = 3'b011;
            if (c == 6) start = 1'b0;
            #1;
            n_done += int'(instrDone);
            if (pcLoad) pcl_cycle = c;
        end
        step();
        check("b2b_instrDone", n_done, 2);
        check("b2b_pcLoad_cycle", pcl_cycle, 6);
        check("b2b_idle", 32'(busy), 32'd0);
        check("b2b_cycleCount", 32'(cycleCount), 32'd6);

        // store timeout into FAULT
        start = 1'b1;
        id = 3'b100;
        memReady = 1'b0;
        n_wm = 0;
        got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            step();
            if (c == 1) start = 1'b0;
            #1;
            n_wm += int'(writeMemory);
            if (fault) got = 1'b1;
        end
        check("fault_reached", 32'(got), 32'd1);
        check("fault_writeMemory_cycles", n_wm, 16);
        check("fault_outputs", 32'(get_outs()), 32'd1);
        check("fault_cycleCount", 32'(cycleCount), 32'd19);
        for (int c = 0; c < 6; c++) begin
            start = c[0] ? 1'b0 : 1'b1;
            memReady = 1'b1;
            step();
        end
        start = 1'b0;
        memReady = 1'b0;
        check("fault_sticky_outputs", 32'(get_outs()), 32'd1);
        check("fault_frozen_count", 32'(cycleCount), 32'd19);
        #2;
        resetN = 1'b0;
        #1;
        check("fault_reset_outputs", 32'(get_outs()), 32'd0);
        check("fault_reset_count", 32'(cycleCount), 32'd0);
        step();
        resetN = 1'b1;

        // asynchronous reset during LOAD MEM
        start = 1'b1;
        id = 3'b010;
        memReady = 1'b0;
        n_done = 0;
        got = 1'b0;
        for (int c = 1; c <= 10 && !got; c++) begin
            step();
            if (c == 1) start = 1'b0;
            #1;
            n_done += int'(instrDone);
            if (memoryRead) got = 1'b1;
        end
        check("arst_mem_entered", 32'(got), 32'd1);
        step();
        #1;
        n_done += int'(instrDone);
        check("arst_memoryRead_before", 32'(memoryRead), 32'd1);
        edges0 = n_edges;
        #2;
        resetN = 1'b0;
        #1;
        check("arst_no_clock_edge", n_edges, edges0);
        check("arst_memoryRead_dropped", 32'(memoryRead), 32'd0);
        check("arst_outputs", 32'(get_outs()), 32'd0);
        check("arst_cycleCount", 32'(cycleCount), 32'd0);
        check("arst_no_instrDone", n_done, 0);
        #2;
        resetN = 1'b1;
        for (int c = 0; c < 2; c++) step();
        check("arst_stays_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
